// File: rtl/apb5_rr_requester_arbiter.sv
// Round-robin arbiter sharing one APB5 requester port among NUM_REQ command sources.
// Sequences IDLE/SETUP/ACCESS, returns responses to the winner and bounds PREADY stalls.
module apb5_rr_requester_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int USER_REQ_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                              pclk,
   input  logic                              presetn,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQ-1:0]                req_write,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
   input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
   input  logic [NUM_REQ*3-1:0]              req_prot,
   output logic [NUM_REQ-1:0]                rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic                              rsp_slverr,
   output logic                              rsp_timeout,
   output logic [ADDR_WIDTH-1:0]             paddr,
   output logic [2:0]                        pprot,
   output logic                              pselx,
   output logic                              penable,
   output logic                              pwrite,
   output logic [DATA_WIDTH-1:0]             pwdata,
   output logic [DATA_WIDTH/8-1:0]           pstrb,
   output logic                              pwakeup,
   output logic [USER_REQ_WIDTH-1:0]         pauser,
   input  logic                              pready,
   input  logic [DATA_WIDTH-1:0]             prdata,
   input  logic                              pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] owner_r;
   logic [CNT_W-1:0] tmo_cnt_r;
   logic [IDX_W-1:0] grant_idx_s;
   logic [IDX_W-1:0] cand_idx_s;
   logic             grant_found_s;
   logic             arb_cycle_s;
   logic             accept_s;
   logic             done_s;
   logic             tmo_hit_s;
   logic             stall_s;

   assign done_s      = (state_r == ST_ACCESS) && pready;
   assign arb_cycle_s = (state_r == ST_IDLE) || done_s;
   assign accept_s    = arb_cycle_s && grant_found_s;
   assign tmo_hit_s   = TMO_EN && (state_r == ST_ACCESS) && !pready && (tmo_cnt_r == TMO_LAST);
   assign stall_s     = TMO_EN && (state_r == ST_ACCESS) && !pready && !tmo_hit_s;

   // Round-robin search: first valid source at or after the pointer, wrapping
   always_comb begin
      grant_idx_s   = '0;
      grant_found_s = 1'b0;
      cand_idx_s    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_idx_s = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
         if (!grant_found_s && req_valid[cand_idx_s]) begin
            grant_idx_s   = cand_idx_s;
            grant_found_s = 1'b1;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Grant strobe is combinational so the source sees acceptance in the same cycle
   always_comb begin
      req_ready = '0;
      if (accept_s) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state decode for the APB transfer sequencer
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (done_s) begin
               state_nxt_s = accept_s ? ST_SETUP : ST_IDLE;
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Registered APB outputs, response pulse, RR pointer and stall counter
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_r     <= ST_IDLE;
         ptr_r       <= '0;
         owner_r     <= '0;
         tmo_cnt_r   <= '0;
         pselx       <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         pprot       <= 3'd0;
         pauser      <= '0;
         pwakeup     <= 1'b0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pwakeup     <= (|req_valid) | pselx;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;

         if (done_s) begin
            rsp_valid[owner_r] <= 1'b1;
            rsp_rdata          <= pwrite ? '0 : prdata;
            rsp_slverr         <= pslverr;
         end else if (tmo_hit_s) begin
            rsp_valid[owner_r] <= 1'b1;
            rsp_slverr         <= 1'b1;
            rsp_timeout        <= 1'b1;
         end

         if (accept_s) begin
            pselx     <= 1'b1;
            penable   <= 1'b0;
            pwrite    <= req_write[grant_idx_s];
            paddr     <= req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata    <= req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            // reads drive all-zero strobes on the bus
            pstrb     <= req_write[grant_idx_s] ? req_strb[grant_idx_s*STRB_W +: STRB_W] : '0;
            pprot     <= req_prot[grant_idx_s*3 +: 3];
            pauser    <= USER_REQ_WIDTH'(grant_idx_s);
            owner_r   <= grant_idx_s;
            ptr_r     <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_W'(1);
            tmo_cnt_r <= '0;
         end else if (done_s || tmo_hit_s) begin
            pselx   <= 1'b0;
            penable <= 1'b0;
         end else if (state_r == ST_SETUP) begin
            penable <= 1'b1;
         end else if (stall_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_apb5_rr_requester_arbiter.sv
// Self-checking bench for apb5_rr_requester_arbiter: directed table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_apb5_rr_requester_arbiter;

   localparam int N   = 4;
   localparam int TMO = 4;

   logic          pclk = 1'b0;
   logic          presetn;
   logic [N-1:0]  req_ready, rsp_valid;
   logic [N*32-1:0] req_addr, req_wdata;
   logic [N-1:0]  req_write;
   logic [N*4-1:0] req_strb;
   logic [N*3-1:0] req_prot;
   logic [31:0]   rsp_rdata, paddr, pwdata, prdata;
   logic          rsp_slverr, rsp_timeout, pselx, penable, pwrite, pwakeup, pready, pslverr;
   logic [2:0]    pprot;
   logic [3:0]    pstrb;
   logic [7:0]    pauser;

   logic [N-1:0]  vmask;
   logic [31:0]   c_addr[N];
   logic [31:0]   c_wdata[N];
   logic          c_write[N];
   logic [3:0]    c_strb[N];
   logic [2:0]    c_prot[N];

   int n_vec = 0;
   int n_err = 0;

   always #5 pclk = ~pclk;

   apb5_rr_requester_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_REQ_WIDTH(8), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(vmask), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
      .rsp_timeout(rsp_timeout), .paddr(paddr), .pprot(pprot), .pselx(pselx),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pwakeup(pwakeup), .pauser(pauser), .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      req_write = '0;
      req_strb  = '0;
      req_prot  = '0;
      for (int s = 0; s < N; s++) begin
         req_addr[s*32 +: 32] = c_addr[s];
         req_wdata[s*32 +: 32] = c_wdata[s];
         req_write[s]          = c_write[s];
         req_strb[s*4 +: 4]    = c_strb[s];
         req_prot[s*3 +: 3]    = c_prot[s];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      vmask   = '0;
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  mask;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          stall;
      logic [31:0] rd;
      logic        err;
      int          g;
      logic [31:0] e_rdata;
      logic        e_err;
      logic        e_to;
   } vec_t;

   vec_t vecs[8];

   // One complete transfer from IDLE; other requesters withdraw after the grant.
   task automatic run_vec(input vec_t v);
      for (int s = 0; s < N; s++) begin
         c_addr[s]  = (s == v.g) ? v.addr  : v.addr ^ (32'h1000 * (s + 1));
         c_wdata[s] = (s == v.g) ? v.wdata : v.wdata ^ (32'h0101_0000 * (s + 1));
         c_write[s] = v.wr;
         c_strb[s]  = (s == v.g) ? 4'hF : 4'h3;
         c_prot[s]  = 3'(s + 1);
      end
      vmask = v.mask;
      pready = 1'b0;
      #1 chk("grant", req_ready, 64'(4'b0001 << v.g));
      @(posedge pclk); #1;
      vmask = '0;
      chk("setup_psel", pselx, 1);
      chk("setup_pen", penable, 0);
      chk("pauser", pauser, v.g);
      chk("paddr", paddr, v.addr);
      chk("pwrite", pwrite, v.wr);
      chk("pwdata", pwdata, v.wdata);
      chk("pstrb", pstrb, v.wr ? 4'hF : 4'h0);
      chk("pprot", pprot, v.g + 1);
      chk("pwakeup_on", pwakeup, 1);
      @(posedge pclk); #1;
      chk("access_pen", penable, 1);
      chk("access_psel", pselx, 1);
      prdata  = v.rd;
      pslverr = v.err;
      if (v.e_to) begin
         repeat (TMO - 1) begin
            @(posedge pclk); #1;
            chk("stall_paddr", paddr, v.addr);
            chk("stall_pen", penable, 1);
            chk("stall_norsp", rsp_valid, 0);
         end
         @(posedge pclk); #1;
         chk("to_rsp_valid", rsp_valid, 64'(4'b0001 << v.g));
         chk("to_psel", pselx, 0);
         chk("to_pen", penable, 0);
         pready = 1'b1;
      end else begin
         repeat (v.stall) begin
            @(posedge pclk); #1;
            chk("stall_paddr", paddr, v.addr);
            chk("stall_pen", penable, 1);
            chk("stall_norsp", rsp_valid, 0);
         end
         pready = 1'b1;
         @(posedge pclk); #1;
         pready = 1'b0;
         chk("rsp_valid", rsp_valid, 64'(4'b0001 << v.g));
         chk("end_psel", pselx, 0);
      end
      chk("rsp_rdata", rsp_rdata, v.e_rdata);
      chk("rsp_slverr", rsp_slverr, v.e_err);
      chk("rsp_timeout", rsp_timeout, v.e_to);
      @(posedge pclk); #1;
      pready = 1'b0;
      chk("rsp_pulse_end", rsp_valid, 0);
      chk("pwakeup_off", pwakeup, 0);
   endtask

   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int i = 0; i < N; i++) begin
         if (m[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      // reference model state
      int m_ph, m_ptr, m_own, m_stall, w, last_w;
      logic m_wr, arb;
      logic [N-1:0] e_rv;
      logic [31:0] e_rd, e_paddr, e_pwdata;
      logic e_err, e_to, e_psel, e_pen, e_wake, e_pwr;
      logic [3:0] e_pstrb;
      int wait_cnt[N];

      for (int s = 0; s < N; s++) begin
         c_addr[s] = '0; c_wdata[s] = '0; c_write[s] = 1'b0; c_strb[s] = '0; c_prot[s] = '0;
      end
      vecs[0] = '{4'b0100, 1'b1, 32'h10,  32'hA5A5_0001, 0, 32'h0,         1'b0, 2, 32'h0,         1'b0, 1'b0};
      vecs[1] = '{4'b1111, 1'b0, 32'h44,  32'h0,         0, 32'h1234_5678, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0};
      vecs[2] = '{4'b0010, 1'b0, 32'h80,  32'h0,         3, 32'hDEAD_BEEF, 1'b1, 1, 32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[3] = '{4'b1001, 1'b1, 32'hC0,  32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 1'b1, 3, 32'h0,         1'b1, 1'b0};
      vecs[4] = '{4'b1001, 1'b0, 32'h100, 32'h0,         9, 32'h5555_5555, 1'b0, 0, 32'h0,         1'b1, 1'b1};
      vecs[5] = '{4'b1101, 1'b0, 32'h140, 32'h0,         1, 32'h0F0F_0F0F, 1'b0, 2, 32'h0F0F_0F0F, 1'b0, 1'b0};
      vecs[6] = '{4'b0011, 1'b1, 32'h180, 32'hCAFE_0006, 2, 32'h0,         1'b0, 0, 32'h0,         1'b0, 1'b0};
      vecs[7] = '{4'b0011, 1'b0, 32'h1C0, 32'h0,         0, 32'h7777_0007, 1'b0, 1, 32'h7777_0007, 1'b0, 1'b0};

      // reset state
      do_reset();
      #1;
      chk("rst_psel", pselx, 0);
      chk("rst_pen", penable, 0);
      chk("rst_wake", pwakeup, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pauser", pauser, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_ready", req_ready, 0);

      // all sources requesting continuously with zero-wait completer
      for (int s = 0; s < N; s++) begin
         c_addr[s] = 32'h200 + 32'(s) * 32'h4; c_write[s] = 1'b0; c_prot[s] = 3'(s);
      end
      vmask = 4'hF;
      pready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (c % 2 == 0) chk("b2b_grant", req_ready, 64'(4'b0001 << exp_ord[c / 2]));
         else            chk("b2b_nogrant", req_ready, 0);
         if (c >= 1) begin
            chk("b2b_psel", pselx, 1);
            chk("b2b_pen", penable, (c % 2 == 0) ? 1 : 0);
         end
         if (c >= 3 && c % 2 == 1) chk("b2b_rsp", rsp_valid, 64'(4'b0001 << exp_ord[(c - 3) / 2]));
         @(posedge pclk); #1;
      end

      // directed table
      do_reset();
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // reset in the middle of ACCESS abandons the transfer and the pointer
      do_reset();
      c_addr[1] = 32'h300; c_write[1] = 1'b1; c_wdata[1] = 32'h1111_2222;
      vmask = 4'b0010;
      @(posedge pclk); #1;
      vmask = '0;
      repeat (2) @(posedge pclk);
      #1 chk("mid_access", penable, 1);
      presetn = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
      chk("abort_psel", pselx, 0);
      chk("abort_pen", penable, 0);
      chk("abort_paddr", paddr, 0);
      chk("abort_pwdata", pwdata, 0);
      chk("abort_rsp", rsp_valid, 0);
      chk("abort_wake", pwakeup, 0);
      pready = 1'b1;
      @(posedge pclk); #1;
      pready = 1'b0;
      chk("abort_late_rsp", rsp_valid, 0);
      vmask = 4'b0110;
      #1 chk("ptr_reset", req_ready, 4'b0010);
      vmask = 4'b1000;
      #1 chk("src3_only", req_ready, 4'b1000);
      vmask = '0;

      // randomized traffic against the reference model
      do_reset();
      m_ph = 0; m_ptr = 0; m_own = 0; m_stall = 0; m_wr = 1'b0; last_w = -1;
      e_rv = '0; e_rd = '0; e_err = 1'b0; e_to = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
      e_wake = 1'b0; e_paddr = '0; e_pwdata = '0; e_pwr = 1'b0; e_pstrb = '0;
      for (int s = 0; s < N; s++) wait_cnt[s] = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(posedge pclk); #1;
         chk("r_rsp_valid", rsp_valid, e_rv);
         if (e_rv != '0) begin
            chk("r_rdata", rsp_rdata, e_rd);
            chk("r_slverr", rsp_slverr, e_err);
            chk("r_timeout", rsp_timeout, e_to);
         end
         chk("r_psel", pselx, e_psel);
         chk("r_pen", penable, e_pen);
         chk("r_wake", pwakeup, e_wake);
         if (e_psel) begin
            chk("r_paddr", paddr, e_paddr);
            chk("r_pauser", pauser, m_own);
            chk("r_pwrite", pwrite, e_pwr);
            if (e_pwr) chk("r_pwdata", pwdata, e_pwdata);
            chk("r_pstrb", pstrb, e_pstrb);
         end
         if (last_w >= 0) vmask[last_w] = 1'b0;
         for (int s = 0; s < N; s++) begin
            if (!vmask[s] && $urandom_range(0, 3) == 0) begin
               c_addr[s]  = $urandom;
               c_wdata[s] = $urandom;
               c_write[s] = 1'($urandom_range(0, 1));
               c_strb[s]  = 4'($urandom);
               c_prot[s]  = 3'($urandom);
               vmask[s]   = 1'b1;
               wait_cnt[s] = 0;
            end
         end
         pready  = ($urandom_range(0, 2) != 0);
         prdata  = $urandom;
         pslverr = ($urandom_range(0, 7) == 0);
         #1;
         arb = (m_ph == 0) || (m_ph == 2 && pready);
         w = arb ? pick(vmask, m_ptr) : -1;
         chk("r_ready", req_ready, (w < 0) ? 64'h0 : 64'(4'b0001 << w));
         e_wake = (|vmask) | e_psel;
         e_rv = '0; e_rd = '0; e_err = 1'b0; e_to = 1'b0;
         if (m_ph == 2) begin
            if (pready) begin
               e_rv[m_own] = 1'b1;
               e_rd  = m_wr ? 32'h0 : prdata;
               e_err = pslverr;
               m_ph  = 0;
            end else if (m_stall + 1 == TMO) begin
               e_rv[m_own] = 1'b1;
               e_err = 1'b1;
               e_to  = 1'b1;
               m_ph  = 0;
            end else begin
               m_stall++;
            end
         end else if (m_ph == 1) begin
            m_ph = 2;
         end
         if (w >= 0) begin
            chk("r_fairness", wait_cnt[w] <= N - 1, 1);
            for (int s = 0; s < N; s++) if (s != w && vmask[s]) wait_cnt[s]++;
            m_ph = 1; m_own = w; m_ptr = (w + 1) % N; m_stall = 0;
            m_wr = c_write[w]; e_pwr = c_write[w];
            e_paddr = c_addr[w]; e_pwdata = c_wdata[w];
            e_pstrb = c_write[w] ? c_strb[w] : 4'h0;
         end
         last_w = w;
         e_psel = (m_ph != 0);
         e_pen  = (m_ph == 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
